svn_seg_scan_capture: RTL and testbench

- Receive-side counterpart of four_dig_svn_seg_display.
- Watches the multiplexed anode/cathode bus (an, ca) and rebuilds the four hex digits being shown.
- Flags illegal segment patterns and stalled scanning.
- Used as an on-chip/bench monitor behind the multiplier display tops, and as a loopback checker on the board.

---
 rtl/svn_seg_pkg.sv | 53 +++++
 rtl/svn_seg_pattern_decoder.sv | 35 +++
 rtl/svn_seg_scan_capture.sv | 161 ++++++++++++++++
 tb/tb_svn_seg_scan_capture.sv | 195 +++++++++++++++++++
 4 files changed

// File: rtl/svn_seg_pkg.sv
// Shared segment constants, anode helpers and capture FSM states for the
// seven-segment scan monitor.
package svn_seg_pkg;

  localparam logic [6:0] SEG_0 = 7'h40;
  localparam logic [6:0] SEG_1 = 7'h79;
  localparam logic [6:0] SEG_2 = 7'h24;
  localparam logic [6:0] SEG_3 = 7'h30;
  localparam logic [6:0] SEG_4 = 7'h19;
  localparam logic [6:0] SEG_5 = 7'h12;
  localparam logic [6:0] SEG_6 = 7'h02;
  localparam logic [6:0] SEG_7 = 7'h78;
  localparam logic [6:0] SEG_8 = 7'h00;
  localparam logic [6:0] SEG_9 = 7'h10;
  localparam logic [6:0] SEG_A = 7'h08;
  localparam logic [6:0] SEG_B = 7'h03;
  localparam logic [6:0] SEG_C = 7'h46;
  localparam logic [6:0] SEG_D = 7'h21;
  localparam logic [6:0] SEG_E = 7'h06;
  localparam logic [6:0] SEG_F = 7'h0E;

  localparam int SEG_IDX_A = 0;
  localparam int SEG_IDX_B = 1;
  localparam int SEG_IDX_C = 2;
  localparam int SEG_IDX_D = 3;
  localparam int SEG_IDX_E = 4;
  localparam int SEG_IDX_F = 5;
  localparam int SEG_IDX_G = 6;

  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_SETTLE = 2'd1,
    ST_HOLD   = 2'd2
  } cap_state_t;

  function automatic logic an_is_onehot(input logic [3:0] an);
    return (an == 4'b1110) || (an == 4'b1101) || (an == 4'b1011) || (an == 4'b0111);
  endfunction

  // Digit index equals the position of the low anode bit: 3 = dig1 ... 0 = dig4.
  function automatic logic [1:0] an_to_idx(input logic [3:0] an);
    logic [1:0] idx;
    idx = 2'd0;
    case (an)
      4'b0111: idx = 2'd3;
      4'b1011: idx = 2'd2;
      4'b1101: idx = 2'd1;
      default: idx = 2'd0;
    endcase
    return idx;
  endfunction

endpackage

// File: rtl/svn_seg_pattern_decoder.sv
// Combinational active-low seven-segment pattern to hex decoder with a
// legality flag for patterns outside the sixteen hex glyphs.
module svn_seg_pattern_decoder
  import svn_seg_pkg::*;
(
  input  logic [6:0] i_ca,
  output logic [3:0] o_hex,
  output logic       o_legal
);

  always_comb begin
    o_hex   = 4'h0;
    o_legal = 1'b1;
    case (i_ca)
      SEG_0:   o_hex = 4'h0;
      SEG_1:   o_hex = 4'h1;
      SEG_2:   o_hex = 4'h2;
      SEG_3:   o_hex = 4'h3;
      SEG_4:   o_hex = 4'h4;
      SEG_5:   o_hex = 4'h5;
      SEG_6:   o_hex = 4'h6;
      SEG_7:   o_hex = 4'h7;
      SEG_8:   o_hex = 4'h8;
      SEG_9:   o_hex = 4'h9;
      SEG_A:   o_hex = 4'hA;
      SEG_B:   o_hex = 4'hB;
      SEG_C:   o_hex = 4'hC;
      SEG_D:   o_hex = 4'hD;
      SEG_E:   o_hex = 4'hE;
      SEG_F:   o_hex = 4'hF;
      default: o_legal = 1'b0;
    endcase
  end

endmodule

// File: rtl/svn_seg_scan_capture.sv
// Monitors a multiplexed 4-digit seven-segment bus and rebuilds the digits.
// Optional product checker enabled by SVN_SEG_CAPTURE_PRODUCT_CHK_EN.
//
// state  | meaning
// IDLE   | an_q not one-hot-low, nothing selected
// SETTLE | one-hot an_q, settle counter running
// HOLD   | digit sampled, waiting for an_q to change
module svn_seg_scan_capture
  import svn_seg_pkg::*;
#(
  parameter int SETTLE_CYC  = 4,
  parameter int TIMEOUT_CYC = 1048576,
  parameter int CNT_W       = 21
) (
  input  logic       clk,
  input  logic       clr,
  input  logic [3:0] an,
  input  logic [6:0] ca,
  output logic [3:0] dig1,
  output logic [3:0] dig2,
  output logic [3:0] dig3,
  output logic [3:0] dig4,
  output logic [3:0] dig_valid,
  output logic [3:0] seg_err,
  output logic       frame_done,
  output logic       stalled
`ifdef SVN_SEG_CAPTURE_PRODUCT_CHK_EN
  ,
  output logic       product_ok
`endif
);

  logic [3:0]       r_an_q, r_an_prev;
  logic [6:0]       r_ca_q;
  cap_state_t       r_state, w_state_next;
  logic [CNT_W-1:0] r_set_cnt, w_set_cnt_next;
  logic [CNT_W-1:0] r_to_cnt, w_to_next;
  logic [3:0]       r_dig [4];
  logic [3:0]       r_valid, r_seg_err, r_mask;
  logic             r_frame_done;
  logic             w_chg, w_onehot, w_sample, w_stall_next, w_mask_full;
  logic [1:0]       w_idx;
  logic [3:0]       w_sel, w_hex;
  logic             w_legal;

  svn_seg_pattern_decoder u_dec (
    .i_ca    (r_ca_q),
    .o_hex   (w_hex),
    .o_legal (w_legal)
  );

  assign w_chg       = (r_an_q != r_an_prev);
  assign w_onehot    = an_is_onehot(r_an_q);
  assign w_idx       = an_to_idx(r_an_q);
  assign w_sel       = w_sample ? (4'b0001 << w_idx) : 4'b0000;
  assign w_mask_full = (r_mask == 4'b1111);

  always_comb begin
    w_state_next   = r_state;
    w_set_cnt_next = r_set_cnt;
    w_sample       = 1'b0;
    case (r_state)
      ST_IDLE: begin
        if (w_onehot) begin
          w_state_next   = ST_SETTLE;
          w_set_cnt_next = CNT_W'(1);
        end
      end
      ST_SETTLE: begin
        if (w_chg) begin
          w_set_cnt_next = CNT_W'(1);
          w_state_next   = w_onehot ? ST_SETTLE : ST_IDLE;
        end else if (r_set_cnt == CNT_W'(SETTLE_CYC)) begin
          w_sample     = 1'b1;
          w_state_next = ST_HOLD;
        end else begin
          w_set_cnt_next = r_set_cnt + 1'b1;
        end
      end
      ST_HOLD: begin
        if (w_chg) begin
          w_set_cnt_next = CNT_W'(1);
          w_state_next   = w_onehot ? ST_SETTLE : ST_IDLE;
        end
      end
      default: w_state_next = ST_IDLE;
    endcase
  end

  always_comb begin
    w_to_next = r_to_cnt;
    if (w_chg)
      w_to_next = '0;
    else if (r_to_cnt != CNT_W'(TIMEOUT_CYC))
      w_to_next = r_to_cnt + 1'b1;
  end
  assign w_stall_next = (w_to_next == CNT_W'(TIMEOUT_CYC));

  always_ff @(posedge clk) begin
    if (clr) r_state <= ST_IDLE;
    else     r_state <= w_state_next;
  end

  always_ff @(posedge clk) begin
    if (clr) begin
      r_an_q       <= 4'hF;
      r_an_prev    <= 4'hF;
      r_ca_q       <= 7'h7F;
      r_set_cnt    <= '0;
      r_to_cnt     <= '0;
      r_dig        <= '{default: 4'h0};
      r_valid      <= 4'h0;
      r_seg_err    <= 4'h0;
      r_mask       <= 4'h0;
      r_frame_done <= 1'b0;
    end else begin
      r_an_q       <= an;
      r_an_prev    <= r_an_q;
      r_ca_q       <= ca;
      r_set_cnt    <= w_set_cnt_next;
      r_to_cnt     <= w_to_next;
      r_frame_done <= w_mask_full && !w_stall_next;
      if (w_stall_next) begin
        r_valid <= 4'h0;
        r_mask  <= 4'h0;
      end else begin
        // A sample landing on the clear cycle seeds the next frame's mask.
        r_mask <= (w_mask_full ? 4'h0 : r_mask) | w_sel;
        if (w_legal) r_valid <= r_valid | w_sel;
      end
      if (w_sample && w_legal)  r_dig[w_idx] <= w_hex;
      if (w_sample && !w_legal) r_seg_err <= r_seg_err | w_sel;
    end
  end

  assign dig1       = r_dig[3];
  assign dig2       = r_dig[2];
  assign dig3       = r_dig[1];
  assign dig4       = r_dig[0];
  assign dig_valid  = r_valid;
  assign seg_err    = r_seg_err;
  assign frame_done = r_frame_done;
  assign stalled    = (r_to_cnt == CNT_W'(TIMEOUT_CYC));

`ifdef SVN_SEG_CAPTURE_PRODUCT_CHK_EN
  logic       r_product_ok;
  logic [7:0] w_prod;

  assign w_prod = $signed({{4{r_dig[3][3]}}, r_dig[3]}) * $signed({{4{r_dig[2][3]}}, r_dig[2]});

  always_ff @(posedge clk) begin
    if (clr || w_stall_next)
      r_product_ok <= 1'b0;
    else if (r_frame_done)
      r_product_ok <= (&r_valid) && ({r_dig[1], r_dig[0]} == w_prod);
  end

  assign product_ok = r_product_ok;
`endif

endmodule

// File: tb/tb_svn_seg_scan_capture.sv
// Directed bench for svn_seg_scan_capture: scans, short holds, illegal
// patterns, timeout, mid-frame clear and the optional product check.
module tb_svn_seg_scan_capture;

  logic       clk = 1'b0;
  logic       clr;
  logic [3:0] an;
  logic [6:0] ca;
  logic [3:0] dig1, dig2, dig3, dig4, dig_valid, seg_err;
  logic       frame_done, stalled;
`ifdef SVN_SEG_CAPTURE_PRODUCT_CHK_EN
  logic       product_ok;
`endif

  int n_tests = 0;
  int n_fail  = 0;
  int fd_count = 0;
  int fd_before;

  always #5 clk = ~clk;

  svn_seg_scan_capture #(
    .SETTLE_CYC  (4),
    .TIMEOUT_CYC (64),
    .CNT_W       (8)
  ) dut (
    .clk        (clk),
    .clr        (clr),
    .an         (an),
    .ca         (ca),
    .dig1       (dig1),
    .dig2       (dig2),
    .dig3       (dig3),
    .dig4       (dig4),
    .dig_valid  (dig_valid),
    .seg_err    (seg_err),
    .frame_done (frame_done),
    .stalled    (stalled)
`ifdef SVN_SEG_CAPTURE_PRODUCT_CHK_EN
    ,
    .product_ok (product_ok)
`endif
  );

  // Pulses are tallied at the active edge, so negedge checks see a settled count.
  always @(posedge clk) if (frame_done) fd_count <= fd_count + 1;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_tests++;
    assert (obs === exp)
    else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic step(input int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic scan(input logic [3:0] a, input logic [6:0] c, input int n);
    an = a;
    ca = c;
    step(n);
  endtask

  initial begin
    an  = 4'hF;
    ca  = 7'h7F;
    clr = 1'b1;
    step(3);
    chk("rst_dig1", 32'(dig1), 32'h0);
    chk("rst_dig4", 32'(dig4), 32'h0);
    chk("rst_valid", 32'(dig_valid), 32'h0);
    chk("rst_seg_err", 32'(seg_err), 32'h0);
    chk("rst_frame_done", 32'(frame_done), 32'h0);
    chk("rst_stalled", 32'(stalled), 32'h0);
    clr = 1'b0;

    // Pass 1: 3,A,0,F
    scan(4'b0111, 7'h30, 8);
    chk("p1_dig1_early", 32'(dig1), 32'h3);
    chk("p1_valid_early", 32'(dig_valid), 32'h8);
    scan(4'b1011, 7'h08, 8);
    scan(4'b1101, 7'h40, 8);
    scan(4'b1110, 7'h0E, 8);
    chk("p1_dig1", 32'(dig1), 32'h3);
    chk("p1_dig2", 32'(dig2), 32'hA);
    chk("p1_dig3", 32'(dig3), 32'h0);
    chk("p1_dig4", 32'(dig4), 32'hF);
    chk("p1_valid", 32'(dig_valid), 32'hF);
    chk("p1_fd_count", 32'(fd_count), 32'd1);

    // Pass 2: 8,b,C,d
    scan(4'b0111, 7'h00, 8);
    scan(4'b1011, 7'h03, 8);
    scan(4'b1101, 7'h46, 8);
    scan(4'b1110, 7'h21, 8);
    chk("p2_dig1", 32'(dig1), 32'h8);
    chk("p2_dig2", 32'(dig2), 32'hB);
    chk("p2_dig3", 32'(dig3), 32'hC);
    chk("p2_dig4", 32'(dig4), 32'hD);
    chk("p2_fd_count", 32'(fd_count), 32'd2);
    chk("p2_seg_err", 32'(seg_err), 32'h0);

    // Anode held only 3 cycles: nothing is captured
    an = 4'hF; clr = 1'b1;
    step(2);
    clr = 1'b0;
    for (int p = 0; p < 2; p++) begin
      scan(4'b0111, 7'h30, 3);
      scan(4'b1011, 7'h08, 3);
      scan(4'b1101, 7'h40, 3);
      scan(4'b1110, 7'h0E, 3);
    end
    scan(4'b1111, 7'h7F, 4);
    chk("short_valid", 32'(dig_valid), 32'h0);
    chk("short_dig1", 32'(dig1), 32'h0);
    chk("short_fd_count", 32'(fd_count), 32'd2);

    // Illegal pattern on digit 3
    scan(4'b0111, 7'h79, 8);
    scan(4'b1011, 7'h24, 8);
    scan(4'b1101, 7'h7F, 8);
    scan(4'b1110, 7'h19, 8);
    chk("ill_seg_err", 32'(seg_err), 32'h2);
    chk("ill_dig1", 32'(dig1), 32'h1);
    chk("ill_dig2", 32'(dig2), 32'h2);
    chk("ill_dig3", 32'(dig3), 32'h0);
    chk("ill_dig4", 32'(dig4), 32'h4);
    chk("ill_valid", 32'(dig_valid), 32'hD);
    chk("ill_fd_count", 32'(fd_count), 32'd3);

    // Timeout: 1110 held; stall first visible 66 negedges after the change
    scan(4'b0111, 7'h30, 8);
    scan(4'b1011, 7'h08, 8);
    scan(4'b1101, 7'h40, 8);
    scan(4'b1110, 7'h0E, 8);
    chk("to_valid_before", 32'(dig_valid), 32'hF);
    chk("to_fd_count", 32'(fd_count), 32'd4);
    step(57);
    chk("to_stalled_edge_lo", 32'(stalled), 32'h0);
    step(1);
    chk("to_stalled", 32'(stalled), 32'h1);
    chk("to_valid", 32'(dig_valid), 32'h0);
    chk("to_dig1", 32'(dig1), 32'h3);
    chk("to_dig2", 32'(dig2), 32'hA);
    chk("to_dig4", 32'(dig4), 32'hF);
    chk("to_seg_err_sticky", 32'(seg_err), 32'h2);
    scan(4'b1101, 7'h40, 2);
    chk("to_stall_clear", 32'(stalled), 32'h0);
    step(6);
    chk("to_recapture_valid", 32'(dig_valid), 32'h2);

    // Clear mid-frame after two captures
    scan(4'b0111, 7'h30, 8);
    scan(4'b1011, 7'h08, 8);
    scan(4'b1101, 7'h40, 3);
    an = 4'hF; clr = 1'b1;
    step(2);
    chk("clr_dig1", 32'(dig1), 32'h0);
    chk("clr_dig2", 32'(dig2), 32'h0);
    chk("clr_valid", 32'(dig_valid), 32'h0);
    chk("clr_seg_err", 32'(seg_err), 32'h0);
    chk("clr_frame_done", 32'(frame_done), 32'h0);
    chk("clr_stalled", 32'(stalled), 32'h0);
    clr = 1'b0;
    fd_before = fd_count;
    scan(4'b0111, 7'h30, 8);
    scan(4'b1011, 7'h08, 8);
    scan(4'b1101, 7'h40, 8);
    scan(4'b1110, 7'h0E, 8);
    scan(4'b1111, 7'h7F, 4);
    chk("clr_one_frame", 32'(fd_count - fd_before), 32'd1);
    chk("clr_valid_after", 32'(dig_valid), 32'hF);

`ifdef SVN_SEG_CAPTURE_PRODUCT_CHK_EN
    // 7 x -2 = -14 = F2
    scan(4'b0111, 7'h78, 8);
    scan(4'b1011, 7'h06, 8);
    scan(4'b1101, 7'h0E, 8);
    scan(4'b1110, 7'h24, 8);
    chk("prod_ok_true", 32'(product_ok), 32'h1);
    scan(4'b0111, 7'h78, 8);
    scan(4'b1011, 7'h06, 8);
    scan(4'b1101, 7'h40, 8);
    scan(4'b1110, 7'h06, 8);
    chk("prod_ok_false", 32'(product_ok), 32'h0);
`endif

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
